// File: rtl/mesh_controller.sv
// Ingress controller between a mesh router port and the neuron core: assembles
// 4-bit flits into 32-bit spike packets, buffers them, and paces their dispatch.
module mesh_controller #(
    parameter int FIFO_DEPTH      = 4,
    parameter int DISPATCH_CYCLES = 16
) (
    input  logic        neu_clk,
    input  logic        rst_n,
    input  logic        write_enable,
    input  logic [3:0]  packet_in,
    output logic        receive_full,
    output logic [31:0] spike_packet,
    output logic        write_req,
    output logic        start
);
    localparam int         PW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0] HOLD_LOAD = 8'(DISPATCH_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, SEND, HOLD, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    nibCnt_q, nibCnt_d;
    logic [27:0]   asm_q, asm_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   spike_q, spike_d;
    logic [7:0]    holdCnt_q, holdCnt_d;
    logic          dispatched_q, dispatched_d;
    logic          accept, push, pop, empty;
    logic [31:0]   pushWord;

    assign receive_full = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign spike_packet = spike_q;
    assign write_req    = (state_q == SEND);
    assign start        = (state_q == DONE);

    // Only the first seven nibbles are stored; the eighth completes the word on the push edge.
    always_comb begin
        accept   = write_enable && !receive_full;
        push     = accept && (nibCnt_q == 3'd7);
        pushWord = {asm_q, packet_in};
        asm_d    = accept ? pushWord[27:0] : asm_q;
        nibCnt_d = accept ? nibCnt_q + 3'd1 : nibCnt_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // SEND and the final IDLE cycle each take one slot of the period, so HOLD covers the rest.
    always_comb begin
        state_d      = state_q;
        spike_d      = spike_q;
        holdCnt_d    = holdCnt_q;
        dispatched_d = dispatched_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    spike_d      = mem_q[rdPtr_q];
                    dispatched_d = 1'b1;
                    state_d      = SEND;
                end else if (dispatched_q && (nibCnt_q == 3'd0) && !write_enable) begin
                    state_d = DONE;
                end
            end
            SEND: begin
                holdCnt_d = HOLD_LOAD;
                state_d   = (HOLD_LOAD == 8'd0) ? IDLE : HOLD;
            end
            HOLD: begin
                holdCnt_d = holdCnt_q - 8'd1;
                if (holdCnt_q == 8'd1) state_d = IDLE;
            end
            DONE: begin
                dispatched_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge neu_clk) begin
        if (push) mem_q[wrPtr_q] <= pushWord;
    end

    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            nibCnt_q     <= '0;
            asm_q        <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            spike_q      <= '0;
            holdCnt_q    <= '0;
            dispatched_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            nibCnt_q     <= nibCnt_d;
            asm_q        <= asm_d;
            count_q      <= count_d;
            spike_q      <= spike_d;
            holdCnt_q    <= holdCnt_d;
            dispatched_q <= dispatched_d;
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_mesh_controller.sv
// Bench for mesh_controller: a paced-dispatch reference model checks the default
// instance every cycle, and a vector table checks a DISPATCH_CYCLES=2 instance.
`timescale 1ns/1ps
module tb_mesh_controller;
    localparam int DEPTH = 4;
    localparam int DC    = 16;

    logic        neu_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_enable = 1'b0;
    logic [3:0]  packet_in = 4'h0;
    logic        full16, wr16, start16, full2, wr2, start2;
    logic [31:0] spike16, spike2;

    mesh_controller dut16 (
        .neu_clk(neu_clk), .rst_n(rst_n), .write_enable(write_enable), .packet_in(packet_in),
        .receive_full(full16), .spike_packet(spike16), .write_req(wr16), .start(start16)
    );

    mesh_controller #(.DISPATCH_CYCLES(2)) dut2 (
        .neu_clk(neu_clk), .rst_n(rst_n), .write_enable(write_enable), .packet_in(packet_in),
        .receive_full(full2), .spike_packet(spike2), .write_req(wr2), .start(start2)
    );

    always #5 neu_clk = ~neu_clk;

    int testsRun = 0;
    int testsFailed = 0;
    int startCount = 0;
    logic [31:0] got[$];

    logic [31:0] mq[$];
    int          mNib, mBusy;
    logic [31:0] mWord, mSpike;
    bit          mDisp, mWr, mStart;

    typedef struct {
        bit          we;
        logic [3:0]  nib;
        bit          expWr;
        logic [31:0] expSpike;
        bit          expStart;
    } vec_t;
    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mNib = 0; mBusy = 0; mWord = '0; mSpike = '0;
        mDisp = 0; mWr = 0; mStart = 0;
    endtask

    // Packets leave the queue one per DC cycles; a burst ends once nothing is queued or half-built.
    task automatic modelStep(input bit we, input logic [3:0] nib);
        bit full, idle;
        full = (mq.size() == DEPTH);
        idle = (mBusy == 0);
        mWr = 0; mStart = 0;
        if (idle && mq.size() != 0) begin
            mSpike = mq.pop_front(); mWr = 1; mBusy = DC - 1; mDisp = 1;
        end else if (idle && mDisp && mNib == 0 && !we) begin
            mStart = 1; mDisp = 0; mBusy = 1;
        end else if (mBusy > 0) begin
            mBusy--;
        end
        if (we && !full) begin
            mWord = {mWord[27:0], nib};
            mNib++;
            if (mNib == 8) begin
                mq.push_back(mWord);
                mNib = 0;
            end
        end
    endtask

    task automatic checkOutput();
        check("receive_full", 32'(full16), 32'(mq.size() == DEPTH));
        check("spike_packet", spike16, mSpike);
        check("write_req", 32'(wr16), 32'(mWr));
        check("start", 32'(start16), 32'(mStart));
    endtask

    task automatic applyStimulus(input bit we, input logic [3:0] nib);
        write_enable = we;
        packet_in    = nib;
        @(posedge neu_clk);
        modelStep(we, nib);
        @(negedge neu_clk);
        checkOutput();
        if (wr16) got.push_back(spike16);
        if (start16) startCount++;
    endtask

    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        write_enable = 1'b0;
        modelReset();
        #1;
        checkOutput();
        check("reset dut2 outputs", {full2, wr2, start2, spike2[28:0]}, 32'h0);
        repeat (cycles) @(posedge neu_clk);
        @(negedge neu_clk);
        rst_n = 1'b1;
        checkOutput();
        got.delete();
        startCount = 0;
    endtask

    task automatic drainUntilStart(input int bound);
        int c;
        c = 0;
        while (startCount == 0 && c < bound) begin
            applyStimulus(1'b0, 4'($urandom));
            c++;
        end
        repeat (20) applyStimulus(1'b0, 4'($urandom));
        check("start pulses in burst", startCount, 1);
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  f;
        int          idx, guard;
        bit          sawFull;

        for (int r = 1; r <= 22; r++) begin
            vecs[r-1].we       = (r <= 16);
            vecs[r-1].nib      = 4'(r);
            vecs[r-1].expWr    = (r == 9 || r == 17);
            vecs[r-1].expSpike = (r < 9) ? 32'h0 : (r < 17) ? 32'h12345678 : 32'h9ABCDEF0;
            vecs[r-1].expStart = (r == 19);
        end

        // Reset and idle: no start without a prior dispatch.
        doReset(2);
        repeat (10) applyStimulus(1'b0, 4'h0);
        check("idle start count", startCount, 0);

        // Basic stream on the DISPATCH_CYCLES=2 instance.
        doReset(2);
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].we, vecs[i].nib);
            check("tbl write_req", 32'(wr2), 32'(vecs[i].expWr));
            check("tbl spike_packet", spike2, vecs[i].expSpike);
            check("tbl start", 32'(start2), 32'(vecs[i].expStart));
            check("tbl receive_full", 32'(full2), 32'h0);
        end

        // Gapped flits.
        doReset(2);
        w = '0;
        for (int i = 0; i < 8; i++) begin
            f = 4'($urandom);
            w = {w[27:0], f};
            applyStimulus(1'b1, f);
            repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 4'($urandom));
        end
        drainUntilStart(100);
        check("gapped packet count", got.size(), 1);
        if (got.size() == 1) check("gapped packet value", got[0], w);

        // Backpressure: flits presented while full are corrupted and must be ignored.
        doReset(2);
        idx = 0; guard = 0; sawFull = 0;
        while (idx < 96 && guard < 2000) begin
            if (mq.size() == DEPTH) begin
                applyStimulus(1'b1, ~4'(idx));
            end else begin
                applyStimulus(1'b1, 4'(idx));
                idx++;
            end
            if (full16) sawFull = 1;
            guard++;
        end
        check("stream completed", 32'(idx), 32'd96);
        check("receive_full seen", 32'(sawFull), 32'd1);
        drainUntilStart(400);
        check("backpressure packet count", got.size(), 12);
        for (int p = 0; p < 12 && p < got.size(); p++)
            check("backpressure packet order", got[p], (p % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF);

        // Mid-packet reset discards the partial packet.
        doReset(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'hF);
        doReset(1);
        repeat (12) applyStimulus(1'b0, 4'h0);
        check("no write_req after reset", got.size(), 0);
        w = 32'hA5C30F96;
        for (int i = 0; i < 8; i++) begin
            f = w[31-4*i -: 4];
            applyStimulus(1'b1, f);
        end
        drainUntilStart(100);
        check("fresh packet count", got.size(), 1);
        if (got.size() == 1) check("fresh packet value", got[0], w);

        // Randomized traffic, then finish the partial packet and drain one burst.
        doReset(2);
        for (int c = 0; c < 1500; c++)
            applyStimulus(($urandom_range(0, 9) < 6), 4'($urandom));
        guard = 0;
        while (mNib != 0 && guard < 400) begin
            applyStimulus(1'b1, 4'($urandom));
            guard++;
        end
        check("partial packet completed", 32'(mNib), 32'd0);
        startCount = 0;
        drainUntilStart(400);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
